// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, full-array reset
// and a per-register busy scoreboard feeding operand-ready flags.
module regfile_mp #(
   parameter int XLEN        = 32,
   parameter int REG_COUNT   = 32,
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 1,
   parameter int ZERO_REG    = 1,
   localparam int AW         = $clog2(REG_COUNT)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [READ_PORTS*AW-1:0]    rd_addr,
   output logic [READ_PORTS*XLEN-1:0]  rd_data,
   output logic [READ_PORTS-1:0]       rd_ready,
   input  logic [WRITE_PORTS-1:0]      wr_en,
   input  logic [WRITE_PORTS*AW-1:0]   wr_addr,
   input  logic [WRITE_PORTS*XLEN-1:0] wr_data,
   input  logic                        iss_en,
   input  logic [AW-1:0]               iss_addr,
   output logic [AW:0]                 busy_count
);

   localparam bit HAS_ZERO = (ZERO_REG != 0);

   logic [XLEN-1:0]        regs       [REG_COUNT];
   logic [REG_COUNT-1:0]   busy;
   logic [REG_COUNT-1:0]   busy_next;
   logic [REG_COUNT-1:0]   iss_mask;
   logic                   iss_hit;

   logic [AW-1:0]          wa         [WRITE_PORTS];
   logic [XLEN-1:0]        wd         [WRITE_PORTS];
   logic [WRITE_PORTS-1:0] wv;

   logic [REG_COUNT-1:0]   ent_we;
   logic [XLEN-1:0]        ent_wd     [REG_COUNT];

   logic [AW-1:0]          ra         [READ_PORTS];
   logic [READ_PORTS-1:0]  hit;
   logic [XLEN-1:0]        hit_data   [READ_PORTS];
   logic [READ_PORTS-1:0]  zero_rd;

   function automatic logic [AW:0] popcount(input logic [REG_COUNT-1:0] v);
      logic [AW:0] n;
      n = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         n = n + {{AW{1'b0}}, v[i]};
      end
      return n;
   endfunction

   // Unpack write ports; a write to the hardwired zero register is treated as
   // no write at all, so it neither updates storage, bypasses nor clears busy.
   always_comb begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
         wa[w] = wr_addr[w*AW +: AW];
         wd[w] = wr_data[w*XLEN +: XLEN];
         wv[w] = wr_en[w] && !(HAS_ZERO && (wa[w] == '0));
      end
   end

   // Per-entry write decode. Ports are scanned in ascending order so the
   // highest-index port targeting an entry is the one that sticks.
   // NOTE: every output of this block gets a default before the loop, so no
   // latch is inferred for entries that nobody writes this cycle.
   always_comb begin
      ent_we = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         ent_wd[i] = '0;
      end
      for (int w = 0; w < WRITE_PORTS; w++) begin
         if (wv[w]) begin
            ent_we[wa[w]] = 1'b1;
            ent_wd[wa[w]] = wd[w];
         end
      end
   end

   // NOTE: the whole array is reset on purpose so that no entry can ever
   // return X; this rules out mapping the storage onto a RAM macro.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (ent_we[i]) begin
               regs[i] <= ent_wd[i];
            end
         end
      end
   end

   // Scoreboard: writeback clears, issue sets, and the set is applied last so
   // a freshly issued producer wins over a retiring one on the same register.
   always_comb begin
      iss_hit  = iss_en && !(HAS_ZERO && (iss_addr == '0));
      iss_mask = '0;
      if (iss_hit) begin
         iss_mask[iss_addr] = 1'b1;
      end
      busy_next = (busy & ~ent_we) | iss_mask;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_next;
         busy_count <= popcount(busy_next);
      end
   end

   // Read ports: bypass from the highest-index matching write port, zero
   // register forced to 0 and always ready.
   always_comb begin
      for (int r = 0; r < READ_PORTS; r++) begin
         ra[r]       = rd_addr[r*AW +: AW];
         zero_rd[r]  = HAS_ZERO && (ra[r] == '0);
         hit[r]      = 1'b0;
         hit_data[r] = '0;
         for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wv[w] && (wa[w] == ra[r])) begin
               hit[r]      = 1'b1;
               hit_data[r] = wd[w];
            end
         end
      end
   end

   // Outputs are gated during reset because bypass hits would otherwise leak
   // live write data while the array itself is held at zero.
   always_comb begin
      rd_data  = '0;
      rd_ready = '1;
      if (rst) begin
         for (int r = 0; r < READ_PORTS; r++) begin
            if (zero_rd[r]) begin
               rd_data[r*XLEN +: XLEN] = '0;
               rd_ready[r]             = 1'b1;
            end else if (hit[r]) begin
               rd_data[r*XLEN +: XLEN] = hit_data[r];
               rd_ready[r]             = 1'b1;
            end else begin
               rd_data[r*XLEN +: XLEN] = regs[ra[r]];
               rd_ready[r]             = !busy[ra[r]];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based model,
// with directed scenarios pinning write, bypass, scoreboard and reset behaviour.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int RC   = 32;
   localparam int RP   = 2;
   localparam int WP   = 2;
   localparam int AW   = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [RP*AW-1:0]  rd_addr;
   logic [RP*XLEN-1:0] rd_data;
   logic [RP-1:0]     rd_ready;
   logic [WP-1:0]     wr_en;
   logic [WP*AW-1:0]  wr_addr;
   logic [WP*XLEN-1:0] wr_data;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;
   logic [AW:0]       busy_count;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_mem  [RC];
   bit              m_busy [RC];

   always #5 clk = ~clk;

   regfile_mp #(
      .XLEN(XLEN), .REG_COUNT(RC), .READ_PORTS(RP), .WRITE_PORTS(WP), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy_count(busy_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < RC; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < RC; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   // Architectural effect of one rising edge, applied from the inputs in force.
   task automatic model_edge();
      if (rst) begin
         for (int w = 0; w < WP; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
               m_mem[wr_addr[w*AW +: AW]]  = wr_data[w*XLEN +: XLEN];
               m_busy[wr_addr[w*AW +: AW]] = 1'b0;
            end
         end
         if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
   endtask

   task automatic compare_comb();
      for (int r = 0; r < RP; r++) begin
         logic [AW-1:0]   a;
         logic [XLEN-1:0] ed;
         logic            er;
         a = rd_addr[r*AW +: AW];
         if (!rst) begin
            ed = '0;
            er = 1'b1;
         end else if (a == 0) begin
            ed = '0;
            er = 1'b1;
         end else begin
            ed = m_mem[a];
            er = !m_busy[a];
            for (int w = 0; w < WP; w++) begin
               if (wr_en[w] && wr_addr[w*AW +: AW] == a) begin
                  ed = wr_data[w*XLEN +: XLEN];
                  er = 1'b1;
               end
            end
         end
         check($sformatf("rd_data[%0d] addr %0d", r, a), 64'(rd_data[r*XLEN +: XLEN]), 64'(ed));
         check($sformatf("rd_ready[%0d] addr %0d", r, a), 64'(rd_ready[r]), 64'(er));
      end
   endtask

   task automatic settle();
      #1;
      compare_comb();
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_edge();
      #1;
      check("busy_count", 64'(busy_count), 64'(model_count()));
   endtask

   task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic ie, input logic [4:0] ia,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      wr_en    = we;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      iss_en   = ie;
      iss_addr = ia;
      rd_addr  = {ra1, ra0};
   endtask

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic randomize_inputs();
      drive(2'($urandom_range(0, 3)), rand_addr(), $urandom(), rand_addr(), $urandom(),
            ($urandom_range(0, 2) == 0), rand_addr(), rand_addr(), rand_addr());
   endtask

   // Asserts reset between edges with random inputs, holds it for n edges and
   // releases it mid-cycle.
   task automatic apply_reset(input int n);
      randomize_inputs();
      #1;
      rst = 1'b0;
      model_clear();
      #1;
      check("busy_count in reset", 64'(busy_count), 64'd0);
      check("rd_ready in reset", 64'(rd_ready), 64'd3);
      check("rd_data in reset", 64'(rd_data), 64'd0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check("busy_count held in reset", 64'(busy_count), 64'd0);
         randomize_inputs();
         #1;
         compare_comb();
      end
      rst = 1'b1;
   endtask

   initial begin
      model_clear();
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
      #2;
      apply_reset(3);

      for (int a = 0; a < RC; a += 2) begin
         drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'(a), 5'(a + 1));
         settle();
         check("post-reset data", 64'(rd_data), 64'd0);
         check("post-reset ready", 64'(rd_ready), 64'd3);
         edge_step();
      end
      check("post-reset busy_count", 64'(busy_count), 64'd0);

      drive(2'b01, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0, 5, 0);
      settle();
      edge_step();
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 5);
      settle();
      check("x5 on port 1", 64'(rd_data[63:32]), 64'hDEADBEEF);
      edge_step();

      drive(2'b01, 0, 32'h1234, 0, 0, 1'b0, 0, 0, 0);
      settle();
      check("x0 write bypass blocked", 64'(rd_data[31:0]), 64'd0);
      edge_step();
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
      settle();
      check("x0 reads zero", 64'(rd_data[31:0]), 64'd0);
      edge_step();

      drive(2'b01, 7, 32'hA5A5A5A5, 0, 0, 1'b0, 0, 7, 0);
      settle();
      check("bypass x7", 64'(rd_data[31:0]), 64'hA5A5A5A5);
      edge_step();
      drive(2'b11, 7, 32'h1, 7, 32'h2, 1'b0, 0, 7, 0);
      settle();
      check("dual write bypass x7", 64'(rd_data[31:0]), 64'h2);
      edge_step();
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 0);
      settle();
      check("dual write stored x7", 64'(rd_data[31:0]), 64'h2);
      edge_step();

      drive(2'b00, 0, 0, 0, 0, 1'b1, 3, 0, 0);
      settle();
      edge_step();
      check("issue x3 count", 64'(busy_count), 64'd1);
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 0);
      settle();
      check("x3 not ready", 64'(rd_ready[0]), 64'd0);
      edge_step();
      drive(2'b01, 3, 32'h55, 0, 0, 1'b0, 0, 3, 0);
      settle();
      check("x3 writeback ready", 64'(rd_ready[0]), 64'd1);
      check("x3 writeback data", 64'(rd_data[31:0]), 64'h55);
      edge_step();
      check("x3 retired count", 64'(busy_count), 64'd0);

      drive(2'b01, 9, 32'h77, 0, 0, 1'b1, 9, 0, 0);
      settle();
      edge_step();
      check("issue+write x9 count", 64'(busy_count), 64'd1);
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 0);
      settle();
      check("x9 data", 64'(rd_data[31:0]), 64'h77);
      check("x9 still busy", 64'(rd_ready[0]), 64'd0);
      edge_step();

      for (int i = 1; i <= 4; i++) begin
         drive(2'b01, 5'(i), 32'h100 + 32'(i), 0, 0, 1'b1, 5'(i), 5'(i), 0);
         settle();
         edge_step();
      end
      check("x1..x4 busy count", 64'(busy_count), 64'd5);
      apply_reset(2);
      for (int i = 1; i <= 4; i += 2) begin
         drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'(i), 5'(i + 1));
         settle();
         check("mid-op reset data", 64'(rd_data), 64'd0);
         check("mid-op reset ready", 64'(rd_ready), 64'd3);
         edge_step();
      end
      check("mid-op reset count", 64'(busy_count), 64'd0);

      for (int c = 0; c < 2000; c++) begin
         randomize_inputs();
         settle();
         edge_step();
         if (c == 1000) apply_reset(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, the successor of the single-write/dual-read core register file. It adds configurable width, depth and port counts, write-to-read bypass, full-array reset, and a per-register busy scoreboard. The decode stage reads operands and marks destinations busy at issue. The writeback stage writes results and clears busy. Operand-ready flags let the hazard unit stall without a separate scoreboard.

Parameters:
XLEN, 32, data width of each register in bits.
REG_COUNT, 32, number of architectural registers; power of two, minimum 2.
READ_PORTS, 2, number of independent combinational read ports, 1..4.
WRITE_PORTS, 1, number of synchronous write ports, 1..2.
ZERO_REG, 1, 1 means register 0 reads as zero, ignores writes and is never busy; 0 means register 0 is an ordinary register.
AW (localparam), clog2(REG_COUNT), address width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
rd_addr  in  READ_PORTS*AW  read addresses; port r uses bits [r*AW +: AW].
rd_data  out  READ_PORTS*XLEN  read data, combinational.
rd_ready  out  READ_PORTS  1 means the operand is valid this cycle (not busy, or bypassed).
wr_en  in  WRITE_PORTS  write strobe per write port.
wr_addr  in  WRITE_PORTS*AW  write addresses.
wr_data  in  WRITE_PORTS*XLEN  write data.
iss_en  in  1  issue strobe: mark iss_addr busy.
iss_addr  in  AW  destination register being issued.
busy_count  out  AW+1  registered number of busy registers.

Behaviour:
- Reset (rst=0, asynchronous):
  - all REG_COUNT entries clear to 0; all busy bits clear; busy_count=0.
  - while rst=0: rd_data=0 and rd_ready=all ones, regardless of inputs.
- Reset release: normal operation starts at the first rising edge after rst goes to 1. Reset mid-operation discards all pending writes, issues and busy state.
- Write (synchronous): on a rising edge with wr_en[w]=1, the entry at wr_addr[w] takes wr_data[w].
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Two ports writing the same address in one cycle: the higher-index port wins.
- Read (combinational, zero latency):
  - rd_data[r] = entry[rd_addr[r]], except as below.
  - Bypass: if any wr_en[w]=1 with wr_addr[w]=rd_addr[r], and the address is not register 0 with ZERO_REG=1, rd_data[r] takes wr_data of the highest-index such port in the same cycle.
  - ZERO_REG=1 and rd_addr[r]=0: rd_data[r]=0 and rd_ready[r]=1 always.
- Ready: rd_ready[r] = !busy[rd_addr[r]] OR bypass hit on port r.
- Busy update (rising edge), per register i:
  - set when iss_en=1 and iss_addr=i;
  - cleared when any wr_en[w]=1 with wr_addr[w]=i;
  - set and clear on the same register in the same cycle: set wins (a new producer is issued).
  - Issue to register 0 with ZERO_REG=1 is ignored.
  - Issue to an already busy register keeps it busy; there is no counting per register.
- busy_count: registered popcount of the next-state busy vector; updates one cycle after the event; range 0..REG_COUNT.
- Writes to a non-busy register are legal: data updates and busy stays 0.
- No X propagation: every entry is defined after reset.

Test Plan:
- Reset: hold rst=0 with random inputs, then release, then read all 32 addresses -> every rd_data=0, every rd_ready=1, busy_count=0.
- Write then read: write 0xDEADBEEF to x5, then read x5 on port 1 next cycle -> 0xDEADBEEF. Write 0x1234 to x0 (ZERO_REG=1) -> x0 reads 0.
- Bypass: in the same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 and rd_addr0=7 -> rd_data0=0xA5A5A5A5 combinationally, before the edge. WRITE_PORTS=2 with both ports writing x7 (0x1, 0x2) -> read returns 0x2 in the same cycle and after the edge.
- Scoreboard: issue x3 -> next cycle rd_ready for x3=0 and busy_count=1. Writeback x3=0x55 -> rd_ready=1 in the same cycle (bypass) and busy_count=0 the cycle after.
- Simultaneous: issue x9 and writeback x9 in the same cycle -> x9 holds the written data, busy[9]=1, busy_count=1.
- Reset mid-operation: with x1..x4 busy and nonzero, pull rst low between edges -> outputs reset immediately; after release all entries=0 and busy_count=0.
